// File: rtl/end_module_pkg.sv
// Shared defaults and types for the end_module complementary-output storage register.
package end_module_pkg;

    localparam int DEFAULT_WIDTH       = 1;
    localparam int DEFAULT_PIPE_STAGES = 1;

    typedef logic [DEFAULT_WIDTH-1:0] data_t;

    localparam data_t DEFAULT_RESET_VALUE = '0;

endpackage

// File: rtl/end_module_stage.sv
// One WIDTH-bit storage stage: async reset, sync clear, enable, and a scan shift path
// that exists only when END_MODULE_SCAN_EN is defined.
module end_module_stage #(
    parameter int               WIDTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
`ifdef END_MODULE_SCAN_EN
    input  logic             scan_en,
    input  logic             scan_in,
    output logic             scan_out,
`endif
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

`ifdef END_MODULE_SCAN_EN
    // Scan enters at bit 0 and leaves from the MSB, so chaining stages gives one long shifter.
    assign scan_out = q[WIDTH-1];

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            q <= RESET_VALUE;
        else if (scan_en)
            q <= WIDTH'({q, scan_in});
        else if (clr)
            q <= RESET_VALUE;
        else if (en)
            q <= d;
    end
`else
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            q <= RESET_VALUE;
        else if (clr)
            q <= RESET_VALUE;
        else if (en)
            q <= d;
    end
`endif

endmodule

// File: rtl/end_module.sv
// Parameterised D register with complementary outputs, PIPE_STAGES deep.
// Define END_MODULE_SCAN_EN to add the scan_en/scan_in/scan_out shift chain.
module end_module
    import end_module_pkg::*;
#(
    parameter int               WIDTH       = DEFAULT_WIDTH,
    parameter int               PIPE_STAGES = DEFAULT_PIPE_STAGES,
    parameter logic [WIDTH-1:0] RESET_VALUE = WIDTH'(DEFAULT_RESET_VALUE)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
`ifdef END_MODULE_SCAN_EN
    input  logic             scan_en,
    input  logic             scan_in,
    output logic             scan_out,
`endif
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb
);

    logic [WIDTH-1:0] stage_q [PIPE_STAGES];

`ifdef END_MODULE_SCAN_EN
    logic [PIPE_STAGES:0] scan_link;
    assign scan_link[0] = scan_in;
    assign scan_out     = scan_link[PIPE_STAGES];
`endif

    // Stage 0 takes d; every later stage takes its predecessor, so the last stage is q.
    for (genvar i = 0; i < PIPE_STAGES; i++) begin : g_stage
        logic [WIDTH-1:0] stage_d;

        if (i == 0) begin : g_first
            assign stage_d = d;
        end else begin : g_next
            assign stage_d = stage_q[i-1];
        end

        end_module_stage #(
            .WIDTH      (WIDTH),
            .RESET_VALUE(RESET_VALUE)
        ) u_stage (
            .clock   (clock),
            .reset   (reset),
            .en      (en),
            .clr     (clr),
`ifdef END_MODULE_SCAN_EN
            .scan_en (scan_en),
            .scan_in (scan_link[i]),
            .scan_out(scan_link[i+1]),
`endif
            .d       (stage_d),
            .q       (stage_q[i])
        );
    end

    assign q  = stage_q[PIPE_STAGES-1];
    assign qb = ~q;

endmodule

// File: tb/tb_end_module.sv
// Scoreboard bench for end_module: four configurations share the control inputs and are
// checked against a queue-based reference model.
module tb_end_module;

    typedef logic [3:0] nib_q_t[$];

    typedef struct {
        logic       a;
        logic       b;
        logic       c;
        logic [3:0] dq;
        logic       so;
    } exp_t;

    localparam logic [3:0] RV_A = 4'h0;
    localparam logic [3:0] RV_B = 4'h1;
    localparam logic [3:0] RV_C = 4'h0;
    localparam logic [3:0] RV_D = 4'h9;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       en    = 1'b1;
    logic       clr   = 1'b0;
    logic       d1    = 1'b1;
    logic [3:0] d4    = 4'h0;

    logic       q_a, qb_a, q_b, qb_b, q_c, qb_c;
    logic [3:0] q_d, qb_d;

`ifdef END_MODULE_SCAN_EN
    logic scan_en = 1'b0;
    logic scan_in = 1'b0;
    logic so_a, so_b, so_c, so_d;
`endif

    int   errors = 0;
    int   checks = 0;
    exp_t exp_q[$];
    nib_q_t ha, hb, hc, hd;

    always #10 clock = ~clock;

    end_module #(.WIDTH(1), .PIPE_STAGES(1), .RESET_VALUE(1'b0)) dut_a (
        .clock(clock), .reset(reset), .en(en), .clr(clr),
`ifdef END_MODULE_SCAN_EN
        .scan_en(1'b0), .scan_in(1'b0), .scan_out(so_a),
`endif
        .d(d1), .q(q_a), .qb(qb_a));

    end_module #(.WIDTH(1), .PIPE_STAGES(1), .RESET_VALUE(1'b1)) dut_b (
        .clock(clock), .reset(reset), .en(en), .clr(clr),
`ifdef END_MODULE_SCAN_EN
        .scan_en(1'b0), .scan_in(1'b0), .scan_out(so_b),
`endif
        .d(d1), .q(q_b), .qb(qb_b));

    end_module #(.WIDTH(1), .PIPE_STAGES(3), .RESET_VALUE(1'b0)) dut_c (
        .clock(clock), .reset(reset), .en(en), .clr(clr),
`ifdef END_MODULE_SCAN_EN
        .scan_en(1'b0), .scan_in(1'b0), .scan_out(so_c),
`endif
        .d(d1), .q(q_c), .qb(qb_c));

    end_module #(.WIDTH(4), .PIPE_STAGES(2), .RESET_VALUE(RV_D)) dut_d (
        .clock(clock), .reset(reset), .en(en), .clr(clr),
`ifdef END_MODULE_SCAN_EN
        .scan_en(scan_en), .scan_in(scan_in), .scan_out(so_d),
`endif
        .d(d4), .q(q_d), .qb(qb_d));

    // Reference model: each queue holds the pipeline contents, newest value at the front.
    function automatic nib_q_t fillQ(input int n, input logic [3:0] rv);
        nib_q_t h;
        for (int i = 0; i < n; i++) h.push_back(rv);
        return h;
    endfunction

    function automatic nib_q_t stepQ(input nib_q_t h, input logic [3:0] rv,
                                     input logic e, input logic c, input logic [3:0] din);
        nib_q_t r = h;
        if (c) begin
            foreach (r[i]) r[i] = rv;
        end else if (e) begin
            r.push_front(din);
            void'(r.pop_back());
        end
        return r;
    endfunction

    // Scan view: one 8-bit shifter, stage0 bit0 at the bottom, last stage MSB at the top.
    function automatic nib_q_t scanQ(input nib_q_t h, input logic sin);
        nib_q_t     r = h;
        logic [7:0] v = {h[1], h[0]};
        v    = {v[6:0], sin};
        r[0] = v[3:0];
        r[1] = v[7:4];
        return r;
    endfunction

    task automatic resetModel();
        ha = fillQ(1, RV_A);
        hb = fillQ(1, RV_B);
        hc = fillQ(3, RV_C);
        hd = fillQ(2, RV_D);
    endtask

    task automatic checkOutput(input string name, input logic [3:0] actual, input logic [3:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at t=%0t", name, actual, expected, $time);
        end
    endtask

    task automatic pushExpect();
        exp_t e;
        e.a  = ha[ha.size()-1][0];
        e.b  = hb[hb.size()-1][0];
        e.c  = hc[hc.size()-1][0];
        e.dq = hd[hd.size()-1];
        e.so = e.dq[3];
        exp_q.push_back(e);
    endtask

    // Drive at a falling edge, advance the model at the rising edge, return on the next falling edge.
    task automatic applyStimulus(input logic e, input logic c, input logic v1, input logic [3:0] v4);
        en = e;
        clr = c;
        d1 = v1;
        d4 = v4;
        @(posedge clock);
        ha = stepQ(ha, RV_A, e, c, {3'b000, v1});
        hb = stepQ(hb, RV_B, e, c, {3'b000, v1});
        hc = stepQ(hc, RV_C, e, c, {3'b000, v1});
`ifdef END_MODULE_SCAN_EN
        if (scan_en)
            hd = scanQ(hd, scan_in);
        else
`endif
        hd = stepQ(hd, RV_D, e, c, v4);
        pushExpect();
        @(negedge clock);
    endtask

    task automatic checkAllAt(input string tag);
        checkOutput({tag, "_q_a"}, {3'b000, q_a}, RV_A);
        checkOutput({tag, "_qb_a"}, {3'b000, qb_a}, {3'b000, ~RV_A[0]});
        checkOutput({tag, "_q_b"}, {3'b000, q_b}, RV_B);
        checkOutput({tag, "_q_c"}, {3'b000, q_c}, RV_C);
        checkOutput({tag, "_q_d"}, q_d, RV_D);
        checkOutput({tag, "_qb_d"}, qb_d, ~RV_D);
    endtask

    always @(negedge clock) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checkOutput("q_a", {3'b000, q_a}, {3'b000, e.a});
            checkOutput("qb_a", {3'b000, qb_a}, {3'b000, ~e.a});
            checkOutput("q_b", {3'b000, q_b}, {3'b000, e.b});
            checkOutput("qb_b", {3'b000, qb_b}, {3'b000, ~e.b});
            checkOutput("q_c", {3'b000, q_c}, {3'b000, e.c});
            checkOutput("q_d", q_d, e.dq);
            checkOutput("qb_d", qb_d, ~e.dq);
`ifdef END_MODULE_SCAN_EN
            checkOutput("scan_out_d", {3'b000, so_d}, {3'b000, e.so});
`endif
        end
    end

    initial begin
        resetModel();
        #15;
        checkAllAt("reset_held");
        @(negedge clock);
        reset = 1'b0;

        applyStimulus(1'b1, 1'b0, 1'b1, 4'h3);
        applyStimulus(1'b1, 1'b0, 1'b0, 4'hC);

        for (int i = 0; i < 5; i++)
            applyStimulus(1'b0, 1'b0, 1'(i % 2 == 0), 4'(i));
        applyStimulus(1'b1, 1'b0, 1'b1, 4'h6);
        applyStimulus(1'b1, 1'b1, 1'b1, 4'hF);
        applyStimulus(1'b0, 1'b1, 1'b1, 4'hF);

        applyStimulus(1'b1, 1'b0, 1'b1, 4'h5);
        applyStimulus(1'b1, 1'b0, 1'b0, 4'hA);
        applyStimulus(1'b1, 1'b0, 1'b1, 4'h7);

        // Reset pulse strictly between edges; outputs must return to reset values at once.
        #3 reset = 1'b1;
        #1 checkAllAt("async_reset");
        #2 reset = 1'b0;
        resetModel();
        for (int i = 0; i < 4; i++)
            applyStimulus(1'b1, 1'b0, 1'b0, 4'h0);

        for (int i = 0; i < 200; i++)
            applyStimulus(1'($urandom_range(3) != 0), 1'($urandom_range(15) == 0),
                          1'($urandom_range(1)), 4'($urandom_range(15)));

`ifdef END_MODULE_SCAN_EN
        begin
            logic [7:0] pattern;
            pattern = 8'hA5;
            scan_en = 1'b1;
            for (int i = 0; i < 16; i++) begin
                scan_in = (i < 8) ? pattern[i] : 1'b0;
                applyStimulus(1'b0, 1'b1, 1'($urandom_range(1)), 4'($urandom_range(15)));
                if (i >= 7)
                    checkOutput("scan_exit_bit", {3'b000, so_d}, {3'b000, pattern[i-7]});
            end
            scan_en = 1'b0;
            for (int i = 0; i < 6; i++)
                applyStimulus(1'b1, 1'b0, 1'($urandom_range(1)), 4'($urandom_range(15)));
        end
`endif

        repeat (2) @(negedge clock);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain: %0d left, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
